axis_slice_sequencer: RTL
=========================

Name: axis_slice_sequencer

Overview:
- Width down-converter for AXI streams: accepts one DIN_WIDTH beat and emits it as successive DOUT_WIDTH slices, lowest bits first.
- Sequences the fixed-offset narrowing used elsewhere on the patgen output path, so every slice of a wide pattern word reaches a narrow consumer.
- Runtime SLICE_COUNT allows trimming unused upper slices per beat.
- AXIS_TX_TLAST marks the final slice of each wide beat.

Parameters:
- DIN_WIDTH, 256, input beat width in bits; must be an integer multiple of DOUT_WIDTH.
- DOUT_WIDTH, 32, output slice width in bits.
- MAX_SLICES (localparam), DIN_WIDTH/DOUT_WIDTH, number of slices in a full beat.
- CW (localparam), $clog2(MAX_SLICES+1), width of the count input.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- SLICE_COUNT  in  CW  slices to emit per beat; sampled only at RX handshake.
- AXIS_RX_TDATA  in  DIN_WIDTH  wide input data.
- AXIS_RX_TVALID  in  1  input valid.
- AXIS_RX_TREADY  out  1  input ready.
- AXIS_TX_TDATA  out  DOUT_WIDTH  current slice.
- AXIS_TX_TVALID  out  1  output valid.
- AXIS_TX_TLAST  out  1  high on the last slice of a beat.
- AXIS_TX_TREADY  in  1  output ready.
- BUSY  out  1  high while a beat is held (state EMIT).

Behaviour:
- Reset (resetn low, async) sets state=IDLE, idx=0, count register=MAX_SLICES, data register=0.
- Reset outputs: TX_TVALID=0, TX_TLAST=0, BUSY=0, RX_TREADY=1.
- TX_TDATA is not qualified during reset.
- Registers: data_r (DIN_WIDTH), idx (CW), cnt_r (CW), state.
- State IDLE:
  - RX_TREADY=1; TX_TVALID=0.
  - On RX_TVALID&&RX_TREADY: data_r<=RX_TDATA; cnt_r<=effective count; idx<=0; state<=EMIT.
- Effective count: SLICE_COUNT==0 or SLICE_COUNT>MAX_SLICES gives MAX_SLICES; otherwise SLICE_COUNT.
- State EMIT:
  - TX_TVALID=1.
  - TX_TDATA=data_r[idx*DOUT_WIDTH +: DOUT_WIDTH].
  - TX_TLAST=(idx==cnt_r-1).
  - BUSY=1.
- TX handshake with TLAST=0: idx<=idx+1.
- TX handshake with TLAST=1:
  - If RX_TVALID is also high, accept a new beat in the same cycle (reload data_r, cnt_r, idx<=0, stay EMIT).
  - Otherwise state<=IDLE, idx<=0.
- RX_TREADY = (state==IDLE) || (state==EMIT && TLAST && TX_TREADY).
  - This is the only combinational TX_TREADY-to-RX_TREADY path and is permitted.
- Latency: slice 0 is valid on the cycle after the RX handshake.
- Throughput: sustained, no bubble between beats when the TX side is always ready. N slices take N cycles per beat.
- Backpressure: with TX_TREADY low, TDATA, TLAST and idx hold stable and TVALID stays high (AXI stability rule).
- SLICE_COUNT changes while in EMIT have no effect on the beat in flight.
- cnt_r=1: every beat produces a single slice with TLAST=1. The design reduces to a registered low-bit slicer.
- idx never exceeds cnt_r-1; no wrap-around into undefined slices.
- resetn asserted mid-beat: the held beat is discarded, outputs take reset values immediately, and no partial TLAST is emitted.

Test Plan:
1. Defaults, SLICE_COUNT=8, TX_TREADY=1, RX beat 0x…0007_0006_0005_0004_0003_0002_0001_0000 (32-bit words):
   - TX emits 0x0,1,2,…,7 on 8 consecutive cycles; TLAST only on 0x7.
   - RX_TREADY low for cycles 1–7, high on the cycle of the 8th slice.
2. Back-to-back: two beats presented continuously, SLICE_COUNT=8, TX_TREADY=1.
   - 16 contiguous valid slices, no idle cycle between slice 7 and the next beat's slice 0.
3. SLICE_COUNT=3, beat with words 0xA0..0xA7:
   - Emits 0xA0,0xA1,0xA2, TLAST on 0xA2; returns to IDLE.
   - SLICE_COUNT=0 and SLICE_COUNT=9 each emit all 8 words.
4. Backpressure: TX_TREADY toggles 1,0,0,1 during slice 2.
   - TDATA held at word 2 and TVALID held high through the stall; the sequence resumes with word 3.
5. Change SLICE_COUNT from 8 to 2 after slice 1 of an 8-slice beat:
   - The current beat still emits 8 slices; the next beat emits 2.
6. Assert resetn low after slice 4:
   - TVALID=0 and BUSY=0 asynchronously, RX_TREADY=1 after release.
   - The next beat starts at slice 0.

Source files
------------

// File: rtl/axis_slice_sequencer.sv
// axis_slice_sequencer: splits each wide AXI-stream beat into narrow slices, lowest bits first
module axis_slice_sequencer #(
  parameter int DIN_WIDTH  = 256,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [$clog2(DIN_WIDTH/DOUT_WIDTH+1)-1:0] SLICE_COUNT,
  input  logic [DIN_WIDTH-1:0]  AXIS_RX_TDATA,
  input  logic                  AXIS_RX_TVALID,
  output logic                  AXIS_RX_TREADY,
  output logic [DOUT_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TVALID,
  output logic                  AXIS_TX_TLAST,
  input  logic                  AXIS_TX_TREADY,
  output logic                  BUSY
);
  localparam int MAX_SLICES = DIN_WIDTH / DOUT_WIDTH;
  localparam int CW         = $clog2(MAX_SLICES + 1);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t                 r_state;
  logic [DIN_WIDTH-1:0]   r_data;
  logic [CW-1:0]          r_idx;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_eff_cnt;
  logic                   w_emit;
  logic                   w_last;
  // zero or oversized counts fall back to a full beat
  always_comb begin
    w_eff_cnt = (SLICE_COUNT == '0 || SLICE_COUNT > CW'(MAX_SLICES)) ? CW'(MAX_SLICES) : SLICE_COUNT;
    w_emit    = (r_state == EMIT);
    w_last    = w_emit && (r_idx == r_cnt - CW'(1));
  end
  assign AXIS_TX_TVALID = w_emit;
  assign AXIS_TX_TLAST  = w_last;
  assign BUSY           = w_emit;
  assign AXIS_TX_TDATA  = r_data[r_idx*DOUT_WIDTH +: DOUT_WIDTH];
  // ready early on the final slice so a new beat follows without a bubble
  assign AXIS_RX_TREADY = !w_emit || (w_last && AXIS_TX_TREADY);
  // beat capture and slice stepping; a last-slice handshake may reload in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= CW'(MAX_SLICES);
      r_data  <= '0;
    end else if (AXIS_RX_TVALID && AXIS_RX_TREADY) begin
      r_state <= EMIT;
      r_data  <= AXIS_RX_TDATA;
      r_cnt   <= w_eff_cnt;
      r_idx   <= '0;
    end else if (w_emit && AXIS_TX_TREADY) begin
      r_state <= w_last ? IDLE : EMIT;
      r_idx   <= w_last ? '0 : r_idx + CW'(1);
    end
  end
endmodule
